// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus_uart peripheral: register offsets,
// STATUS bit positions and the state encoding used by both serial FSMs.
package uart_pkg;

  // Register offsets, as word index addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_FRAME_ERR = 5;

  // Frame phases, shared by the transmitter and the receiver
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/bus_uart_fifo.sv
// Synchronous FIFO buffering TX bytes. A push on a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module bus_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values, modelling real registers.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; entries are only ever read after being written, so a reset buys nothing.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: bus register interface, FIFO-buffered
// transmitter and single-entry receiver with overrun/framing flags.
module bus_uart
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int          TX_FIFO_DEPTH = 8,
  parameter logic [15:0] DEFAULT_DIV   = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        done,
  output logic        active,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

  // Bus side
  logic        accept, wr_acc, rd_acc;
  logic [1:0]  offset;
  logic        done_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status_word;
  logic [15:0] div_q;

  // Receive holding register and flags
  logic        rx_valid_q, overrun_q, frame_err_q;
  logic [7:0]  rx_byte_q;
  logic        rx_pop, rx_load, ovr_set, w1c;

  // TX FIFO
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  // Transmitter
  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        tx_bit_end, tx_busy;

  // Receiver
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [16:0] rx_half;
  logic        rx_mid, rx_bit_end, rx_done, rx_ferr;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], wmask[3:2]};

  // ---------------------------------------------------------------- bus
  assign active  = (addr[31:4] == BASE_ADDR[31:4]);
  assign accept  = (wen | ren) & active & ~done_q;
  assign wr_acc  = accept & wen;
  assign rd_acc  = accept & ~wen;
  assign offset  = addr[3:2];
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign uart_tx = tx_q;

  assign fifo_push = wr_acc & (offset == REG_DATA) & wmask[0];
  assign w1c       = wr_acc & (offset == REG_STATUS) & wmask[0];
  assign rx_pop    = rd_acc & (offset == REG_DATA) & rx_valid_q;
  assign tx_busy   = (tx_state_q != IDLE) | (fifo_count != '0);

  // A byte arriving while the holder is being read out replaces it cleanly
  assign rx_load = rx_done & (~rx_valid_q | rx_pop);
  assign ovr_set = rx_done & rx_valid_q & ~rx_pop;

  // STATUS register image
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    status_word               = '0;
    status_word[ST_TX_FULL]   = fifo_full;
    status_word[ST_TX_EMPTY]  = fifo_empty;
    status_word[ST_RX_VALID]  = rx_valid_q;
    status_word[ST_OVERRUN]   = overrun_q;
    status_word[ST_TX_BUSY]   = tx_busy;
    status_word[ST_FRAME_ERR] = frame_err_q;
  end

  // Read mux; a write (even with ren also high) returns zero
  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      case (offset)
        REG_DATA:   rdata_d = {23'b0, rx_valid_q, rx_byte_q};
        REG_STATUS: rdata_d = status_word;
        REG_DIV:    rdata_d = {16'b0, div_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // Single-cycle response: done and rdata registered one cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= accept;
      rdata_q <= rdata_d;
    end
  end

  // Baud divisor with byte-masked writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
    end else if (wr_acc && offset == REG_DIV) begin
      if (wmask[0]) div_q[7:0]  <= wdata[7:0];
      if (wmask[1]) div_q[15:8] <= wdata[15:8];
    end
  end

  // Receive holding register and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= rx_sh_q;
      end else if (rx_pop) begin
        rx_valid_q <= 1'b0;
      end
      if (ovr_set)                overrun_q <= 1'b1;
      else if (w1c && wdata[3])   overrun_q <= 1'b0;
      if (rx_ferr)                frame_err_q <= 1'b1;
      else if (w1c && wdata[5])   frame_err_q <= 1'b0;
    end
  end

  bus_uart_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------- transmitter
  // Each bit latches the divisor at its start, so a DIVISOR write only
  // affects the following bit.
  assign tx_bit_end = (tx_cnt_q == tx_div_q);

  // TX next-state: serialize start, 8 data bits LSB first, stop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_sh_d    = fifo_head;
          tx_div_d   = div_q;
          tx_d       = 1'b0;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_div_d   = div_q;
          tx_bit_d   = 3'd0;
          tx_d       = tx_sh_q[0];
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_div_d = div_q;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end
      end
      STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next frame so queued bytes leave gap-free
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_sh_d    = fifo_head;
            tx_div_d   = div_q;
            tx_d       = 1'b0;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end
      end
    endcase
  end

  // TX state register; line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  // ------------------------------------------------------------- receiver
  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Half a bit period, in 17 bits so DIVISOR=0xFFFF does not wrap
  assign rx_half    = ({1'b0, rx_div_q} + 17'd1) >> 1;
  assign rx_mid     = (({1'b0, rx_cnt_q} + 17'd1) >= rx_half);
  assign rx_bit_end = (rx_cnt_q == rx_div_q);

  // RX next-state: qualify start at mid-bit, then sample one period apart
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = div_q;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_mid) begin
          rx_cnt_d = '0;
          rx_div_d = div_q;
          rx_bit_d = 3'd0;
          // Line back high at mid-start means a glitch, not a frame
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_div_d = div_q;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          if (rx_s2_q) rx_done = 1'b1;
          else         rx_ferr = 1'b1;
        end
      end
    endcase
  end

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Directed testbench for bus_uart: register access, TX framing and FIFO,
// RX reception with overrun / framing error / glitch rejection, reset.
module tb_bus_uart;

  localparam logic [31:0] A_DATA = 32'h4000_0000;
  localparam logic [31:0] A_STAT = 32'h4000_0004;
  localparam logic [31:0] A_DIV  = 32'h4000_0008;
  localparam logic [31:0] A_RSV  = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        done;
  logic        active;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] tx_exp [10];

  bus_uart dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .wmask   (wmask),
    .wen     (wen),
    .ren     (ren),
    .rdata   (rdata),
    .done    (done),
    .active  (active),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // One bus transaction: drive at negedge, hold until done, sample after posedge
  task automatic bus_xfer(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    addr = a; wdata = d; wmask = m; wen = we; ren = re;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done && lat < 8);
    rd = rdata;
    if (!done) begin
      $display("FAIL bus_timeout addr=%h: done=0 after %0d cycles, want 1", a, lat);
      total_cnt++;
    end
    wen = 1'b0; ren = 1'b0; wmask = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] rd; int lat;
    bus_xfer(1'b1, 1'b0, a, d, m, rd, lat);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
    int lat;
    bus_xfer(1'b0, 1'b1, a, '0, '0, rd, lat);
  endtask

  // Watch uart_tx: wait for a start bit, then compare every clock of n frames
  task automatic capture_tx(input int nframes, input int bit_clks, input int idle_clks);
    int waited;
    int errs;
    int first_bad;
    logic exp_b;
    waited = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && waited < 300) begin
      @(negedge clk); waited++;
    end
    total_cnt++;
    if (uart_tx !== 1'b0) begin
      $display("FAIL tx_start_timeout: uart_tx=%b after %0d clocks, want 0", uart_tx, waited);
      return;
    end
    pass_cnt++;
    for (int f = 0; f < nframes; f++) begin
      errs = 0; first_bad = -1;
      for (int i = 0; i < 10 * bit_clks; i++) begin
        int k;
        k = i / bit_clks;
        if (k == 0)      exp_b = 1'b0;
        else if (k == 9) exp_b = 1'b1;
        else             exp_b = tx_exp[f][k-1];
        if (uart_tx !== exp_b) begin
          if (errs == 0) first_bad = i;
          errs++;
        end
        @(negedge clk);
      end
      total_cnt++;
      if (errs != 0)
        $display("FAIL tx_frame%0d byte=%h: %0d wrong clocks (first at %0d), want 0", f, tx_exp[f], errs, first_bad);
      else pass_cnt++;
    end
    errs = 0;
    for (int i = 0; i < idle_clks; i++) begin
      if (uart_tx !== 1'b1) errs++;
      @(negedge clk);
    end
    total_cnt++;
    if (errs != 0) $display("FAIL tx_idle_after: %0d low clocks, want 0", errs);
    else pass_cnt++;
  endtask

  // Drive one 8N1 frame at 4 clocks per bit with a chosen stop level
  task automatic send_rx(input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    uart_rx = 1'b0; repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; repeat (4) @(negedge clk);
    end
    uart_rx = stop_b; repeat (4) @(negedge clk);
    uart_rx = 1'b1; repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; int dones;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (uart_tx !== 1'b1 || done !== 1'b0 || rdata !== 32'h0)
      $display("FAIL reset_outputs: tx=%b done=%b rdata=%h, want 1 0 0", uart_tx, done, rdata);
    else pass_cnt++;
    rst = 1'b0;
    bus_xfer(1'b0, 1'b1, A_STAT, '0, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'h02) $display("FAIL status_reset: got %h want %h", rd, 32'h02); else pass_cnt++;
    total_cnt++;
    if (lat !== 1) $display("FAIL read_latency: got %0d want 1", lat); else pass_cnt++;
    bus_read(A_DIV, rd);
    total_cnt++;
    if (rd !== 32'd103) $display("FAIL div_reset: got %0d want 103", rd); else pass_cnt++;
    // Decode boundaries
    @(negedge clk); addr = 32'h4000_0010; #1;
    total_cnt++;
    if (active !== 1'b0) $display("FAIL active_above: got %b want 0", active); else pass_cnt++;
    addr = 32'h4000_000C; #1;
    total_cnt++;
    if (active !== 1'b1) $display("FAIL active_top: got %b want 1", active); else pass_cnt++;
    addr = 32'h3FFF_FFFC; #1;
    total_cnt++;
    if (active !== 1'b0) $display("FAIL active_below: got %b want 0", active); else pass_cnt++;
    // Out-of-window strobe must never complete
    addr = 32'h4000_0010; ren = 1'b1; dones = 0;
    repeat (4) begin @(posedge clk); #1; if (done) dones++; end
    ren = 1'b0;
    total_cnt++;
    if (dones != 0) $display("FAIL miss_no_done: %0d done pulses, want 0", dones); else pass_cnt++;
  endtask

  task automatic test_done_pulse();
    logic exp_d;
    repeat (2) @(negedge clk);
    addr = A_STAT; ren = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_d = (i % 2 == 0);
      total_cnt++;
      if (done !== exp_d) $display("FAIL done_pulse%0d: got %b want %b", i, done, exp_d);
      else pass_cnt++;
    end
    ren = 1'b0;
  endtask

  task automatic test_tx_frame();
    logic [31:0] rd; int lat;
    // wen and ren together: the write wins and rdata reads 0
    bus_xfer(1'b1, 1'b1, A_DIV, 32'h0000_0003, 4'b0011, rd, lat);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL wr_rd_priority: got %h want 0", rd); else pass_cnt++;
    bus_read(A_DIV, rd);
    total_cnt++;
    if (rd !== 32'd3) $display("FAIL div_write: got %0d want 3", rd); else pass_cnt++;
    bus_write(A_RSV, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_RSV, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL reserved: got %h want 0", rd); else pass_cnt++;
    tx_exp[0] = 8'hA5;
    fork
      begin
        logic [31:0] st;
        bus_write(A_DATA, 32'h0000_00A5, 4'b0001);
        bus_read(A_STAT, st);
        total_cnt++;
        if (st !== 32'h12) $display("FAIL status_busy: got %h want %h", st, 32'h12); else pass_cnt++;
      end
      capture_tx(1, 4, 8);
    join
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h02) $display("FAIL status_after_tx: got %h want %h", rd, 32'h02); else pass_cnt++;
  endtask

  // Ten quick writes: the first is popped at once, 1..8 fill the FIFO, 9 drops
  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) tx_exp[i] = 8'(i);
    fork
      begin
        logic [31:0] st;
        for (int b = 0; b < 9; b++) bus_write(A_DATA, 32'(b), 4'b0001);
        bus_read(A_STAT, st);
        total_cnt++;
        if (st !== 32'h11) $display("FAIL status_full: got %h want %h", st, 32'h11); else pass_cnt++;
        bus_write(A_DATA, 32'h0000_0009, 4'b0001);
      end
      capture_tx(9, 4, 44);
    join
  endtask

  task automatic test_rx_basic();
    logic [31:0] rd;
    send_rx(8'h3C, 1'b1);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h06) $display("FAIL rx_status: got %h want %h", rd, 32'h06); else pass_cnt++;
    bus_read(A_DATA, rd);
    total_cnt++;
    if (rd !== 32'h13C) $display("FAIL rx_data: got %h want %h", rd, 32'h13C); else pass_cnt++;
    bus_read(A_DATA, rd);
    total_cnt++;
    if (rd !== 32'h03C) $display("FAIL rx_data_popped: got %h want %h", rd, 32'h03C); else pass_cnt++;
  endtask

  task automatic test_rx_overrun();
    logic [31:0] rd;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h0E) $display("FAIL ovr_status: got %h want %h", rd, 32'h0E); else pass_cnt++;
    bus_read(A_DATA, rd);
    total_cnt++;
    if (rd !== 32'h111) $display("FAIL ovr_keep_old: got %h want %h", rd, 32'h111); else pass_cnt++;
    bus_write(A_STAT, 32'h0000_0008, 4'b0010);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h0A) $display("FAIL w1c_masked: got %h want %h", rd, 32'h0A); else pass_cnt++;
    bus_write(A_STAT, 32'h0000_0008, 4'b0001);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h02) $display("FAIL w1c_overrun: got %h want %h", rd, 32'h02); else pass_cnt++;
  endtask

  task automatic test_rx_errors();
    logic [31:0] rd;
    send_rx(8'h55, 1'b0);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h22) $display("FAIL frame_err: got %h want %h", rd, 32'h22); else pass_cnt++;
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (50) @(negedge clk);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h22) $display("FAIL glitch_status: got %h want %h", rd, 32'h22); else pass_cnt++;
    bus_read(A_DATA, rd);
    total_cnt++;
    if (rd !== 32'h011) $display("FAIL glitch_data: got %h want %h", rd, 32'h011); else pass_cnt++;
    bus_write(A_STAT, 32'h0000_0020, 4'b0001);
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h02) $display("FAIL w1c_frame_err: got %h want %h", rd, 32'h02); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd; int lows;
    bus_write(A_DATA, 32'h0, 4'b0001);
    bus_write(A_DATA, 32'h0, 4'b0001);
    repeat (6) @(negedge clk);
    total_cnt++;
    if (uart_tx !== 1'b0) $display("FAIL midframe_low: got %b want 0", uart_tx); else pass_cnt++;
    rst = 1'b1; #1;
    total_cnt++;
    if (uart_tx !== 1'b1 || done !== 1'b0)
      $display("FAIL async_reset: tx=%b done=%b, want 1 0", uart_tx, done);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    bus_read(A_STAT, rd);
    total_cnt++;
    if (rd !== 32'h02) $display("FAIL flush_status: got %h want %h", rd, 32'h02); else pass_cnt++;
    bus_read(A_DIV, rd);
    total_cnt++;
    if (rd !== 32'd103) $display("FAIL div_rereset: got %0d want 103", rd); else pass_cnt++;
    lows = 0;
    repeat (60) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    total_cnt++;
    if (lows != 0) $display("FAIL flush_idle: %0d low clocks, want 0", lows); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_done_pulse();
    test_tx_frame();
    test_back_to_back();
    test_rx_basic();
    test_rx_overrun();
    test_rx_errors();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
